// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises them as
// start / LSB-first data / optional parity / 1-2 stop bit frames on TX.
module uart_tx_engine #(
    parameter int         DATA_WIDTH      = 8,
    parameter int         DIV_WIDTH       = 16,
    parameter logic [3:0] FIFO_EMPTY_MASK = 4'b0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_uart,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    input  logic [DATA_WIDTH-1:0] frdata,
    input  logic [3:0]            frstatus,
    output logic                  fread,
    output logic                  TX,
    output logic                  tx_busy,
    output logic                  tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  stop2_q, stop2_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  fread_q, fread_d;
    logic                  done_q, done_d;

    logic fifo_ready;
    logic tick;

    assign fifo_ready = enable_uart && ((frstatus & FIFO_EMPTY_MASK) == 4'd0);
    assign tick       = (baud_cnt_q == div_q);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        fread_d    = 1'b0;
        done_d     = 1'b0;

        // Bit-time counter runs in every serialising state.
        if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
            baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_ready) begin
                    fread_d = 1'b1;
                    state_d = WAIT_READ;
                end
            end
            WAIT_READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO data is valid now, one clock after the pop strobe.
                shift_d    = frdata;
                div_d      = baud_div;
                par_mode_d = parity_mode;
                stop2_d    = stop_bits;
                case (parity_mode)
                    2'b01:   parity_d = ^frdata;
                    2'b10:   parity_d = ~^frdata;
                    default: parity_d = 1'b1;
                endcase
                tx_d       = 1'b0;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = START;
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (par_mode_q != 2'b00) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (!stop2_q || bit_cnt_q == 4'd1) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        if (fifo_ready) begin
                            fread_d = 1'b1;
                            state_d = WAIT_READ;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            par_mode_q <= 2'b00;
            stop2_q    <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            fread_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            fread_q    <= fread_d;
            done_q     <= done_d;
        end
    end

    assign TX      = tx_q;
    assign fread   = fread_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: FIFO model feeds bytes, expected frames are queued
// at push time and checked bit-by-bit against TX as each frame is transmitted.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_uart = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_bits = 1'b0;
    logic [7:0]  frdata = 8'h00;
    logic [3:0]  frstatus;
    logic        fread, TX, tx_busy, tx_done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [1:0] pm;
        logic       s2;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] fifo_mem [0:63];
    int pushed_cnt = 0;
    int popped_cnt = 0;
    int fread_cnt = 0;
    int cyc = 0;
    int last_fread = 0;
    bit have_last = 1'b0;
    int rate_viol = 0;

    always #5 clk = ~clk;

    // Empty flag is bit 0; the other bits toggle so only the mask bit matters.
    assign frstatus = (pushed_cnt == popped_cnt) ? 4'b0001 : 4'b1010;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fread === 1'b1) begin
            frdata     <= fifo_mem[popped_cnt[5:0]];
            popped_cnt <= popped_cnt + 1;
            fread_cnt  <= fread_cnt + 1;
            if (have_last && (cyc - last_fread) < 3) rate_viol <= rate_viol + 1;
            last_fread <= cyc;
            have_last  <= 1'b1;
        end
    end

    uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_EMPTY_MASK(4'b0001)) dut (
        .clk(clk), .reset(reset), .enable_uart(enable_uart), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .frdata(frdata),
        .frstatus(frstatus), .fread(fread), .TX(TX), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    task automatic push_byte(input logic [7:0] d, input int div);
        exp_t e;
        e.data = d;
        e.div  = div;
        e.pm   = parity_mode;
        e.s2   = stop_bits;
        exp_q.push_back(e);
        fifo_mem[pushed_cnt[5:0]] = d;
        pushed_cnt = pushed_cnt + 1;
    endtask

    // Waits for the start bit, then checks every clock of the frame and the
    // tx_done pulse that follows. Returns on the negedge where tx_done is seen.
    task automatic check_frame(output int waited);
        exp_t e;
        logic [11:0] bits;
        int nb, cpb, bad, done_bad;
        waited = 0;
        if (exp_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got frame request, required queued entry");
            return;
        end
        e = exp_q.pop_front();
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
        nb = 9;
        if (e.pm != 2'b00) begin
            bits[nb] = (e.pm == 2'b01) ? ^e.data : (e.pm == 2'b10) ? ~^e.data : 1'b1;
            nb++;
        end
        bits[nb] = 1'b1; nb++;
        if (e.s2) begin bits[nb] = 1'b1; nb++; end
        cpb = e.div + 1;
        while (waited < 300) begin
            @(negedge clk);
            if (TX === 1'b0) break;
            waited++;
        end
        tests_run++;
        if (waited >= 300) begin
            tests_failed++;
            $display("[TB] FAIL start_timeout: data=%02h no start bit within %0d clocks", e.data, waited);
            return;
        end
        bad = 0; done_bad = 0;
        for (int k = 0; k < nb * cpb; k++) begin
            if (k > 0) @(negedge clk);
            if (TX !== bits[k / cpb]) bad++;
            if (tx_done !== 1'b0) done_bad++;
        end
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL frame_bits: data=%02h got %0d wrong TX clocks, required 0", e.data, bad);
        end
        tests_run++;
        if (done_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL done_early: data=%02h tx_done high %0d clocks in frame, required 0", e.data, done_bad);
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL tx_done: data=%02h got %b after last stop, required 1", e.data, tx_done);
        end
        $display("[TB] frame data=%02h div=%0d parity=%0d stop2=%0d bits=%0d wait=%0d",
                 e.data, e.div, e.pm, e.s2, nb, waited);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 4;
        if (TX !== 1'b1)      begin tests_failed++; $display("[TB] FAIL reset_tx: got %b required 1", TX); end
        if (fread !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_fread: got %b required 0", fread); end
        if (tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b required 0", tx_busy); end
        if (tx_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b required 0", tx_done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        int w, f0;
        f0 = fread_cnt;
        baud_div = 16'd2; parity_mode = 2'b00; stop_bits = 1'b0;
        enable_uart = 1'b1;
        push_byte(8'hA5, 2);
        check_frame(w);
        tests_run += 4;
        if (w != 2) begin tests_failed++; $display("[TB] FAIL latency: got %0d idle clocks before start, required 2", w); end
        if (tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_after: got %b required 0", tx_busy); end
        if (fread !== 1'b0) begin tests_failed++; $display("[TB] FAIL fread_after: got %b required 0", fread); end
        if (fread_cnt - f0 != 1) begin tests_failed++; $display("[TB] FAIL fread_count_8n1: got %0d required 1", fread_cnt - f0); end
    endtask

    task automatic test_parity();
        int w;
        logic [1:0] modes [3];
        modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
        baud_div = 16'd0; stop_bits = 1'b0;
        foreach (modes[i]) begin
            parity_mode = modes[i];
            push_byte(8'h07, 0);
            check_frame(w);
            @(negedge clk);
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_back_to_back();
        int w, f0;
        f0 = fread_cnt;
        enable_uart = 1'b0;
        baud_div = 16'd1; parity_mode = 2'b00; stop_bits = 1'b1;
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        @(negedge clk);
        enable_uart = 1'b1;
        check_frame(w);
        tests_run++;
        if (fread !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_fread: got %b with first tx_done, required 1", fread); end
        check_frame(w);
        tests_run += 2;
        if (w != 1) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d extra high clocks, required 1", w); end
        if (fread_cnt - f0 != 2) begin tests_failed++; $display("[TB] FAIL fread_count_b2b: got %0d required 2", fread_cnt - f0); end
        stop_bits = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty_fifo();
        int bad_fread, bad_tx, bad_busy;
        bad_fread = 0; bad_tx = 0; bad_busy = 0;
        enable_uart = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (fread !== 1'b0) bad_fread++;
            if (TX !== 1'b1) bad_tx++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        tests_run += 3;
        if (bad_fread != 0) begin tests_failed++; $display("[TB] FAIL empty_fread: got %0d high clocks required 0", bad_fread); end
        if (bad_tx != 0) begin tests_failed++; $display("[TB] FAIL empty_tx: got %0d low clocks required 0", bad_tx); end
        if (bad_busy != 0) begin tests_failed++; $display("[TB] FAIL empty_busy: got %0d busy clocks required 0", bad_busy); end
        $display("[TB] empty fifo idle check over 100 clocks");
    endtask

    task automatic test_cfg_change();
        int w1, w2;
        enable_uart = 1'b0;
        baud_div = 16'd3; parity_mode = 2'b00; stop_bits = 1'b0;
        push_byte(8'h3C, 3);
        push_byte(8'h5A, 1);
        @(negedge clk);
        enable_uart = 1'b1;
        fork
            begin
                check_frame(w1);
                check_frame(w2);
            end
            begin
                repeat (20) @(negedge clk);
                baud_div = 16'd1;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int w;
        baud_div = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;
        enable_uart = 1'b1;
        push_byte(8'h81, 1);
        push_byte(8'h42, 1);
        w = 0;
        while (w < 300 && TX !== 1'b0) begin @(negedge clk); w++; end
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run += 3;
        if (TX !== 1'b1)      begin tests_failed++; $display("[TB] FAIL midreset_tx: got %b required 1", TX); end
        if (fread !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midreset_fread: got %b required 0", fread); end
        if (tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b required 0", tx_busy); end
        // The byte in flight was already popped and is lost.
        void'(exp_q.pop_front());
        check_frame(w);
        @(negedge clk);
    endtask

    task automatic test_fread_rate();
        tests_run++;
        if (rate_viol != 0) begin tests_failed++; $display("[TB] FAIL fread_rate: got %0d close pulses required 0", rate_viol); end
        tests_run++;
        if (popped_cnt != pushed_cnt) begin tests_failed++; $display("[TB] FAIL fifo_drain: got %0d pops required %0d", popped_cnt, pushed_cnt); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_empty_fifo();
        test_cfg_change();
        test_reset_mid_frame();
        test_fread_rate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
